adjust_engine: RTL and testbench



---
 rtl/adjust_engine.sv | 207 ++++++++++++++++++++
 tb/tb_adjust_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_engine.sv
// Working-copy editor for time, date and alarms of the digital clock, stepped one BCD field at a time.
// Defining ADJUST_AUTOREPEAT_EN adds hold-to-repeat on the keys; the default build steps once per key press.
module adjust_engine #(
  parameter int ALARM_SLOTS = 2,
  parameter int HOUR_MAX    = 23
`ifdef ADJUST_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                model,
  input  logic                      date_time_ch,
  input  logic [1:0]                adjust_shif,
  input  logic [1:0]                alarm_sel,
  input  logic                      key_up,
  input  logic                      key_down,
  input  logic [23:0]               time_num,
  input  logic [23:0]               data_num,
  output logic [23:0]               adjust_time_num,
  output logic [23:0]               adjust_date_num,
  output logic [16*ALARM_SLOTS-1:0] adjust_clock_num,
  output logic [ALARM_SLOTS-1:0]    alarm_en,
  output logic                      time_load,
  output logic                      date_load
);

  localparam logic [1:0] MODE_ALARM  = 2'b01;
  localparam logic [1:0] MODE_ADJUST = 2'b11;
  localparam logic [7:0] HOUR_BCD    = 8'(((HOUR_MAX / 10) * 16) + (HOUR_MAX % 10));

  // Out-of-range or non-BCD values snap to the field minimum instead of stepping.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                          input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < lo || v > hi) r = lo;
    else if (up) begin
      if (v == hi)               r = lo;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = v + 8'd1;
    end else begin
      if (v == lo)               r = hi;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = v - 8'd1;
    end
    return r;
  endfunction

  // A two-digit BCD year is a multiple of four when (tens even, ones 0/4/8) or (tens odd, ones 2/6).
  function automatic logic is_leap(input logic tens_odd, input logic [1:0] ones_lo);
    return tens_odd ? (ones_lo == 2'd2) : (ones_lo == 2'd0);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [23:0]                  time_q, time_d, date_q, date_d;
  logic [ALARM_SLOTS-1:0][15:0] alarm_q, alarm_d;
  logic [ALARM_SLOTS-1:0]       alarm_en_q, alarm_en_d;
  logic                         time_dirty_q, time_dirty_d, date_dirty_q, date_dirty_d;
  logic                         time_load_q, time_load_d, date_load_q, date_load_d;
  logic                         key_up_q, key_down_q;
  logic [1:0]                   model_q;
  logic                         up_rise, down_rise, up_ev, down_ev, step, entering, leaving;
  logic [7:0]                   new_dim;

  assign up_rise   = key_up & ~key_up_q;
  assign down_rise = key_down & ~key_down_q;
  assign entering  = (model == MODE_ADJUST) && (model_q != MODE_ADJUST);
  assign leaving   = (model != MODE_ADJUST) && (model_q == MODE_ADJUST);

`ifdef ADJUST_AUTOREPEAT_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        repeating_q, repeating_d, rpt_fire;

  // Counter runs only while exactly one key stays held in an unchanged mode after its initial step.
  always_comb begin
    hold_cnt_d  = 32'd0;
    repeating_d = 1'b0;
    rpt_fire    = 1'b0;
    if ((key_up ^ key_down) && !(up_rise || down_rise) && (model == model_q)) begin
      repeating_d = repeating_q;
      if (hold_cnt_q == 32'(repeating_q ? REPEAT_CYCLES - 1 : HOLD_CYCLES - 1)) begin
        rpt_fire    = 1'b1;
        repeating_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= 32'd0;
      repeating_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      repeating_q <= repeating_d;
    end
  end

  assign up_ev   = up_rise | (rpt_fire & key_up);
  assign down_ev = down_rise | (rpt_fire & key_down);
`else
  assign up_ev   = up_rise;
  assign down_ev = down_rise;
`endif

  assign step = up_ev ^ down_ev;

  always_comb begin
    time_d       = time_q;
    date_d       = date_q;
    alarm_d      = alarm_q;
    alarm_en_d   = alarm_en_q;
    time_dirty_d = time_dirty_q;
    date_dirty_d = date_dirty_q;
    time_load_d  = 1'b0;
    date_load_d  = 1'b0;
    new_dim      = 8'h31;
    if (entering) begin
      time_d       = time_num;
      date_d       = data_num;
      time_dirty_d = 1'b0;
      date_dirty_d = 1'b0;
    end else if (model == MODE_ADJUST && step && adjust_shif != 2'b11) begin
      if (!date_time_ch) begin
        time_dirty_d = 1'b1;
        case (adjust_shif)
          2'b00:   time_d[7:0]   = bcd_step(time_q[7:0], up_ev, 8'h00, 8'h59);
          2'b01:   time_d[15:8]  = bcd_step(time_q[15:8], up_ev, 8'h00, 8'h59);
          default: time_d[23:16] = bcd_step(time_q[23:16], up_ev, 8'h00, HOUR_BCD);
        endcase
      end else begin
        date_dirty_d = 1'b1;
        case (adjust_shif)
          2'b00:   date_d[7:0]   = bcd_step(date_q[7:0], up_ev, 8'h01,
                                     days_in_month(date_q[15:8], is_leap(date_q[20], date_q[17:16])));
          2'b01:   date_d[15:8]  = bcd_step(date_q[15:8], up_ev, 8'h01, 8'h12);
          default: date_d[23:16] = bcd_step(date_q[23:16], up_ev, 8'h00, 8'h99);
        endcase
        new_dim = days_in_month(date_d[15:8], is_leap(date_d[20], date_d[17:16]));
        if (adjust_shif != 2'b00 && date_d[7:0] > new_dim) date_d[7:0] = new_dim;
      end
    end else if (model == MODE_ALARM && step) begin
      for (int k = 0; k < ALARM_SLOTS; k++) begin
        if (alarm_sel == 2'(k)) begin
          case (adjust_shif)
            2'b00:   alarm_d[k][7:0]  = bcd_step(alarm_q[k][7:0], up_ev, 8'h00, 8'h59);
            2'b01:   alarm_d[k][15:8] = bcd_step(alarm_q[k][15:8], up_ev, 8'h00, HOUR_BCD);
            2'b11:   alarm_en_d[k]    = ~alarm_en_q[k];
            default: ;
          endcase
        end
      end
    end
    if (leaving) begin
      time_load_d  = time_dirty_q;
      date_load_d  = date_dirty_q;
      time_dirty_d = 1'b0;
      date_dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q       <= 24'h000000;
      date_q       <= 24'h000101;
      alarm_q      <= '0;
      alarm_en_q   <= '0;
      time_dirty_q <= 1'b0;
      date_dirty_q <= 1'b0;
      time_load_q  <= 1'b0;
      date_load_q  <= 1'b0;
      key_up_q     <= 1'b0;
      key_down_q   <= 1'b0;
      model_q      <= 2'b00;
    end else begin
      time_q       <= time_d;
      date_q       <= date_d;
      alarm_q      <= alarm_d;
      alarm_en_q   <= alarm_en_d;
      time_dirty_q <= time_dirty_d;
      date_dirty_q <= date_dirty_d;
      time_load_q  <= time_load_d;
      date_load_q  <= date_load_d;
      key_up_q     <= key_up;
      key_down_q   <= key_down;
      model_q      <= model;
    end
  end

  assign adjust_time_num  = time_q;
  assign adjust_date_num  = date_q;
  assign adjust_clock_num = alarm_q;
  assign alarm_en         = alarm_en_q;
  assign time_load        = time_load_q;
  assign date_load        = date_load_q;

endmodule

// File: tb/tb_adjust_engine.sv
// Scoreboard bench for adjust_engine: directed key sequences push expected snapshots and load strobes,
// and a negedge monitor compares them against the DUT outputs.
module tb_adjust_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  model, adjust_shif, alarm_sel;
  logic        date_time_ch, key_up, key_down;
  logic [23:0] time_num, data_num;
  logic [23:0] adjust_time_num, adjust_date_num;
  logic [31:0] adjust_clock_num;
  logic [1:0]  alarm_en;
  logic        time_load, date_load;

  typedef struct packed {
    logic [23:0] t;
    logic [23:0] d;
    logic [31:0] c;
    logic [1:0]  en;
  } exp_t;

  exp_t       expQueue[$];
  string      nameQueue[$];
  logic [1:0] strobeQueue[$];
  int         checkCount = 0;
  int         passCount  = 0;

  adjust_engine #(.ALARM_SLOTS(2), .HOUR_MAX(23)) dut (
    .clk(clk), .rst_n(rst_n), .model(model), .date_time_ch(date_time_ch),
    .adjust_shif(adjust_shif), .alarm_sel(alarm_sel), .key_up(key_up), .key_down(key_down),
    .time_num(time_num), .data_num(data_num), .adjust_time_num(adjust_time_num),
    .adjust_date_num(adjust_date_num), .adjust_clock_num(adjust_clock_num),
    .alarm_en(alarm_en), .time_load(time_load), .date_load(date_load)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s.%s: got %h, required %h", name, field, act, req);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic dtc,
                               input logic [1:0] shif, input logic [1:0] asel);
    @(posedge clk); #1;
    model = m; date_time_ch = dtc; adjust_shif = shif; alarm_sel = asel;
  endtask

  task automatic pressKeys(input logic up, input logic dn, input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1; key_up = up; key_down = dn;
      @(posedge clk); #1; key_up = 1'b0; key_down = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [23:0] t, input logic [23:0] d,
                             input logic [31:0] c, input logic [1:0] en);
    exp_t e;
    @(posedge clk); #1;
    e.t = t; e.d = d; e.c = c; e.en = en;
    expQueue.push_back(e);
    nameQueue.push_back(name);
  endtask

  // Monitor: drains pending snapshots and matches every load strobe the DUT raises.
  initial begin
    exp_t       e;
    string      n;
    logic [1:0] s;
    forever begin
      @(negedge clk);
      while (expQueue.size() > 0) begin
        e = expQueue.pop_front();
        n = nameQueue.pop_front();
        compareField(n, "time", {8'h0, adjust_time_num}, {8'h0, e.t});
        compareField(n, "date", {8'h0, adjust_date_num}, {8'h0, e.d});
        compareField(n, "alarms", adjust_clock_num, e.c);
        compareField(n, "alarm_en", {30'h0, alarm_en}, {30'h0, e.en});
      end
      if (time_load || date_load) begin
        if (strobeQueue.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_strobe: got time_load=%b date_load=%b, required none",
                   time_load, date_load);
        end else begin
          s = strobeQueue.pop_front();
          compareField("strobe", "time_load,date_load", {30'h0, time_load, date_load}, {30'h0, s});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; model = 2'b00; date_time_ch = 1'b0; adjust_shif = 2'b00; alarm_sel = 2'b00;
    key_up = 1'b0; key_down = 1'b0; time_num = 24'h235846; data_num = 24'h200628;
    repeat (3) @(posedge clk);
    checkOutput("reset_hold", 24'h000000, 24'h000101, 32'h0, 2'b00);
    @(posedge clk); #1; rst_n = 1'b1;
    checkOutput("reset_release", 24'h000000, 24'h000101, 32'h0, 2'b00);

    // Time editing, wraps and key-edge corner cases
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00);
    checkOutput("snapshot", 24'h235846, 24'h200628, 32'h0, 2'b00);
    pressKeys(1'b1, 1'b0, 20);
    checkOutput("sec_up20", 24'h235806, 24'h200628, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b01, 2'b00);
    pressKeys(1'b1, 1'b0, 15);
    checkOutput("min_up15", 24'h231306, 24'h200628, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b10, 2'b00);
    pressKeys(1'b1, 1'b0, 15);
    checkOutput("hour_up15", 24'h141306, 24'h200628, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00);
    pressKeys(1'b0, 1'b1, 6);
    checkOutput("sec_down6", 24'h141300, 24'h200628, 32'h0, 2'b00);
    pressKeys(1'b0, 1'b1, 1);
    checkOutput("sec_down_wrap", 24'h141359, 24'h200628, 32'h0, 2'b00);
    pressKeys(1'b1, 1'b1, 1);
    checkOutput("both_keys", 24'h141359, 24'h200628, 32'h0, 2'b00);
    @(posedge clk); #1; key_up = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    key_up = 1'b0;
    checkOutput("held_key", 24'h141300, 24'h200628, 32'h0, 2'b00);
    strobeQueue.push_back(2'b10);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);
    checkOutput("exit_time", 24'h141300, 24'h200628, 32'h0, 2'b00);
    pressKeys(1'b1, 1'b0, 2);
    checkOutput("mode00_keys", 24'h141300, 24'h200628, 32'h0, 2'b00);
    applyStimulus(2'b10, 1'b0, 2'b00, 2'b00);
    pressKeys(1'b0, 1'b1, 2);
    checkOutput("mode10_keys", 24'h141300, 24'h200628, 32'h0, 2'b00);

    // Date editing, snapshot retention across date_time_ch, and dirty-by-return
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00);
    checkOutput("snapshot2", 24'h235846, 24'h200628, 32'h0, 2'b00);
    pressKeys(1'b1, 1'b0, 3);
    checkOutput("day_up3", 24'h235846, 24'h200601, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b1, 2'b01, 2'b00);
    pressKeys(1'b0, 1'b1, 4);
    checkOutput("month_down4", 24'h235846, 24'h200201, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00);
    checkOutput("dtc_toggle", 24'h235846, 24'h200201, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b11, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("shif11_adjust", 24'h235846, 24'h200201, 32'h0, 2'b00);
    strobeQueue.push_back(2'b01);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);
    checkOutput("exit_date", 24'h235846, 24'h200201, 32'h0, 2'b00);
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    pressKeys(1'b0, 1'b1, 1);
    checkOutput("return_value", 24'h235846, 24'h200628, 32'h0, 2'b00);
    strobeQueue.push_back(2'b10);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);

    // Day clamping and out-of-range snapshots
    data_num = 24'h200229;
    applyStimulus(2'b11, 1'b1, 2'b10, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("clamp_year", 24'h235846, 24'h210228, 32'h0, 2'b00);
    strobeQueue.push_back(2'b01);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);
    data_num = 24'h000131;
    applyStimulus(2'b11, 1'b1, 2'b01, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("clamp_month", 24'h235846, 24'h000229, 32'h0, 2'b00);
    strobeQueue.push_back(2'b01);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);
    data_num = 24'h200600;
    time_num = 24'h127530;
    applyStimulus(2'b11, 1'b1, 2'b00, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    applyStimulus(2'b11, 1'b0, 2'b01, 2'b00);
    pressKeys(1'b0, 1'b1, 1);
    checkOutput("out_of_range", 24'h120030, 24'h200601, 32'h0, 2'b00);
    strobeQueue.push_back(2'b11);
    applyStimulus(2'b00, 1'b0, 2'b00, 2'b00);
    checkOutput("exit_both", 24'h120030, 24'h200601, 32'h0, 2'b00);

    // Alarm slots and enables
    applyStimulus(2'b01, 1'b0, 2'b00, 2'b01);
    pressKeys(1'b1, 1'b0, 15);
    applyStimulus(2'b01, 1'b0, 2'b01, 2'b01);
    pressKeys(1'b1, 1'b0, 25);
    checkOutput("alarm1_set", 24'h120030, 24'h200601, 32'h0115_0000, 2'b00);
    applyStimulus(2'b01, 1'b0, 2'b11, 2'b01);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("alarm1_enable", 24'h120030, 24'h200601, 32'h0115_0000, 2'b10);
    applyStimulus(2'b01, 1'b0, 2'b10, 2'b01);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("alarm_shif10", 24'h120030, 24'h200601, 32'h0115_0000, 2'b10);
    applyStimulus(2'b01, 1'b0, 2'b11, 2'b11);
    pressKeys(1'b1, 1'b0, 1);
    applyStimulus(2'b01, 1'b0, 2'b00, 2'b11);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("alarm_sel3", 24'h120030, 24'h200601, 32'h0115_0000, 2'b10);
    applyStimulus(2'b01, 1'b0, 2'b00, 2'b00);
    pressKeys(1'b0, 1'b1, 1);
    checkOutput("alarm0_down_wrap", 24'h120030, 24'h200601, 32'h0115_0059, 2'b10);

    // Reset in the middle of an edit
    time_num = 24'h235846;
    data_num = 24'h200628;
    applyStimulus(2'b11, 1'b0, 2'b00, 2'b00);
    pressKeys(1'b1, 1'b0, 1);
    checkOutput("pre_reset_edit", 24'h235847, 24'h200628, 32'h0115_0059, 2'b10);
    @(posedge clk); #1; rst_n = 1'b0;
    checkOutput("mid_reset", 24'h000000, 24'h000101, 32'h0, 2'b00);
    model = 2'b00;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("after_reset", 24'h000000, 24'h000101, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    checkCount++;
    if (strobeQueue.size() == 0) passCount++;
    else $display("[TB] FAIL strobe_pending: got %0d strobes missing, required 0", strobeQueue.size());
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
